// File: rtl/seq_shift_unit_pkg.sv
// Shared types and constants for the sequential shift unit.
package seq_shift_unit_pkg;

  // Controller states: waiting for work, stepping, one-cycle completion
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic BIT_ZERO = 1'b0;
  localparam logic BIT_ONE  = 1'b1;

endpackage

// File: rtl/seq_shift_unit_step.sv
// One shift step: left, logical right or arithmetic right by k positions.
// The caller guarantees k != 0 (zero is remapped to one when latched).
module shift_step_comb
  import seq_shift_unit_pkg::*;
#(
  parameter int DW     = 16,
  parameter int STEP_W = 2
) (
  input  logic [DW-1:0]     i_value,
  input  logic [STEP_W-1:0] i_k,
  input  logic              i_dir,
  input  logic              i_arith,
  output logic [DW-1:0]     o_value,
  output logic              o_bit
);

  localparam logic [STEP_W-1:0] K_ONE = STEP_W'(1);

  logic [STEP_W-1:0] w_km1;
  logic [DW-1:0]     w_left;
  logic [DW-1:0]     w_right_log;
  logic [DW-1:0]     w_right_ari;
  logic [DW-1:0]     w_left_pre;
  logic [DW-1:0]     w_right_pre;

  // Shifting by k-1 first moves the last bit to leave into the edge position
  assign w_km1       = i_k - K_ONE;
  assign w_left      = i_value << i_k;
  assign w_right_log = i_value >> i_k;
  assign w_right_ari = DW'($signed(i_value) >>> i_k);
  assign w_left_pre  = i_value << w_km1;
  assign w_right_pre = i_value >> w_km1;

  // Select result and boundary bit by direction and fill mode
  always_comb begin
    o_value = w_left;
    o_bit   = w_left_pre[DW-1];
    if (i_dir == DIR_RIGHT) begin
      o_value = i_arith ? w_right_ari : w_right_log;
      o_bit   = w_right_pre[0];
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-mode sequential shift register: load an operand, then apply a
// programmed number of shift steps under a start/busy/done handshake.
// Handshake: start is accepted only in IDLE on a rising edge; busy is high
// while a job is in flight (SHIFT, DONE); done pulses for exactly one cycle
// after the last shift; hold freezes register and counter in SHIFT only.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int DW     = 16,
  parameter int STEP_W = 2,
  parameter int CNT_W  = $clog2(DW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     data_in,
  input  logic              dir,
  input  logic              arith,
  input  logic [STEP_W-1:0] step,
  input  logic [CNT_W-1:0]  n_steps,
  input  logic              hold,
  output logic [DW-1:0]     shift_out,
  output logic              carry_out,
  output logic              busy,
  output logic              done,
  output shift_state_t      dbg_state
);

  shift_state_t      r_state;
  logic [DW-1:0]     r_data;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dir;
  logic              r_arith;
  logic [STEP_W-1:0] r_step;

  logic [DW-1:0]     w_next;
  logic              w_bit;

  shift_step_comb #(
    .DW     (DW),
    .STEP_W (STEP_W)
  ) u_step (
    .i_value (r_data),
    .i_k     (r_step),
    .i_dir   (r_dir),
    .i_arith (r_arith),
    .o_value (w_next),
    .o_bit   (w_bit)
  );

  // Controller, counter, latched mode and data register with registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_carry <= BIT_ZERO;
      r_busy  <= BIT_ZERO;
      r_done  <= BIT_ZERO;
      r_cnt   <= '0;
      r_dir   <= BIT_ZERO;
      r_arith <= BIT_ZERO;
      r_step  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_data  <= data_in;
            r_carry <= BIT_ZERO;
            r_dir   <= dir;
            r_arith <= arith;
            r_step  <= (step == '0) ? STEP_W'(1) : step;
            r_cnt   <= n_steps;
            r_busy  <= BIT_ONE;
            if (n_steps != '0) begin
              r_state <= SHIFT;
              r_done  <= BIT_ZERO;
            end else begin
              r_state <= DONE;
              r_done  <= BIT_ONE;
            end
          end
        end
        SHIFT: begin
          if (!hold) begin
            r_data  <= w_next;
            r_carry <= w_bit;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= DONE;
              r_done  <= BIT_ONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= BIT_ZERO;
          r_done  <= BIT_ZERO;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= BIT_ZERO;
          r_done  <= BIT_ZERO;
        end
      endcase
    end
  end

  assign shift_out = r_data;
  assign carry_out = r_carry;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: directed vector table, hand-written hold and
// reset sequences, and randomized jobs checked against a reference model.
module tb_seq_shift_unit;
  import seq_shift_unit_pkg::*;

  localparam int DW     = 16;
  localparam int STEP_W = 2;
  localparam int CNT_W  = $clog2(DW + 1);

  logic              clk;
  logic              rst;
  logic              start;
  logic [DW-1:0]     data_in;
  logic              dir;
  logic              arith;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  n_steps;
  logic              hold;
  logic [DW-1:0]     shift_out;
  logic              carry_out;
  logic              busy;
  logic              done;
  shift_state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0]     data;
    logic              dir;
    logic              arith;
    logic [STEP_W-1:0] step;
    int                n;
    logic [DW-1:0]     exp_data;
    logic              exp_carry;
  } vec_t;

  vec_t vecs[8];

  seq_shift_unit #(.DW(DW), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .dir       (dir),
    .arith     (arith),
    .step      (step),
    .n_steps   (n_steps),
    .hold      (hold),
    .shift_out (shift_out),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value and last boundary bit after nsh steps, plain arithmetic
  function automatic void ref_model(input int unsigned t_data, input bit t_dir, input bit t_arith,
                                    input int unsigned t_step, input int nsh,
                                    output int unsigned v, output bit c);
    int unsigned k;
    int unsigned mask;
    int unsigned sign;
    k    = (t_step == 0) ? 1 : t_step;
    mask = (32'd1 << DW) - 1;
    v    = t_data & mask;
    c    = 1'b0;
    for (int i = 0; i < nsh; i++) begin
      if (!t_dir) begin
        c = ((v >> (DW - k)) & 1) != 0;
        v = (v * (32'd1 << k)) & mask;
      end else begin
        c    = ((v >> (k - 1)) & 1) != 0;
        sign = (v >> (DW - 1)) & 1;
        v    = v / (32'd1 << k);
        if (t_arith && sign != 0) v = v | (mask & ~(mask >> k));
      end
    end
  endfunction

  // Run one job; checks every cycle against the model
  task automatic run_job(input logic [DW-1:0] t_data, input logic t_dir, input logic t_arith,
                         input logic [STEP_W-1:0] t_step, input int t_n,
                         input logic [63:0] hold_mask, input bit noise,
                         output logic [DW-1:0] fin_data, output logic fin_carry,
                         output int cycles);
    int shifts;
    int cyc;
    int unsigned ev;
    bit ec;
    @(negedge clk);
    start   = 1'b1;
    data_in = t_data;
    dir     = t_dir;
    arith   = t_arith;
    step    = t_step;
    n_steps = CNT_W'(t_n);
    hold    = 1'($urandom_range(0, 1));
    @(negedge clk);
    start  = 1'b0;
    shifts = 0;
    ev     = 0;
    ec     = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      ref_model(t_data, t_dir, t_arith, t_step, shifts, ev, ec);
      check("busy_in_job", busy, 1);
      check("shift_out", shift_out, ev & 32'hFFFF);
      check("carry_out", carry_out, ec);
      check("done", done, shifts == t_n);
      if (shifts == t_n) break;
      hold = hold_mask[cyc % 64];
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        data_in = DW'($urandom);
        dir     = 1'($urandom_range(0, 1));
        arith   = 1'($urandom_range(0, 1));
        step    = STEP_W'($urandom_range(0, 3));
        n_steps = CNT_W'($urandom_range(0, 16));
      end
      @(negedge clk);
      if (!hold) shifts++;
    end
    if (cyc >= 200) check("job_timeout", 0, 1);
    cycles = cyc;
    // Hold or start during DONE must not stretch or restart anything
    hold = 1'($urandom_range(0, 1));
    if (noise) start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_state", dbg_state, IDLE);
    check("held_out", shift_out, ev & 32'hFFFF);
    check("held_carry", carry_out, ec);
    fin_data  = shift_out;
    fin_carry = carry_out;
  endtask

  initial begin
    logic [DW-1:0] fd;
    logic fc;
    int cyc;
    logic [DW-1:0] r_d;
    logic r_dir_v;
    logic r_ar;
    logic [STEP_W-1:0] r_st;
    int r_n;

    vecs[0] = '{16'h0001, 1'b0, 1'b0, 2'd1, 4, 16'h0010, 1'b0};
    vecs[1] = '{16'h8000, 1'b1, 1'b1, 2'd3, 2, 16'hFE00, 1'b0};
    vecs[2] = '{16'h8000, 1'b1, 1'b0, 2'd3, 2, 16'h0200, 1'b0};
    vecs[3] = '{16'h8001, 1'b0, 1'b0, 2'd1, 3, 16'h0008, 1'b0};
    vecs[4] = '{16'h1234, 1'b0, 1'b0, 2'd2, 0, 16'h1234, 1'b0};
    vecs[5] = '{16'h0003, 1'b0, 1'b0, 2'd0, 1, 16'h0006, 1'b0};
    vecs[6] = '{16'hC000, 1'b0, 1'b0, 2'd1, 1, 16'h8000, 1'b1};
    vecs[7] = '{16'h0005, 1'b1, 1'b0, 2'd1, 1, 16'h0002, 1'b1};

    // Reset with random inputs: outputs clear before any clock edge
    rst     = 1'b1;
    start   = 1'($urandom_range(0, 1));
    data_in = DW'($urandom);
    dir     = 1'($urandom_range(0, 1));
    arith   = 1'($urandom_range(0, 1));
    step    = STEP_W'($urandom_range(0, 3));
    n_steps = CNT_W'($urandom_range(0, 16));
    hold    = 1'($urandom_range(0, 1));
    #2;
    check("rst_shift_out", shift_out, 0);
    check("rst_carry", carry_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    @(negedge clk);
    check("idle_hold_out", shift_out, 0);

    // Directed table; start/inputs toggled during busy must be ignored
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i].data, vecs[i].dir, vecs[i].arith, vecs[i].step, vecs[i].n,
              64'd0, 1'b1, fd, fc, cyc);
      check($sformatf("vec%0d_data", i), fd, vecs[i].exp_data);
      check($sformatf("vec%0d_carry", i), fc, vecs[i].exp_carry);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].n);
    end

    // Hold for three cycles after the first shift delays done by three
    run_job(16'h8001, 1'b0, 1'b0, 2'd1, 3, 64'h000000000000000E, 1'b0, fd, fc, cyc);
    check("hold_data", fd, 16'h0008);
    check("hold_carry", fc, 1'b0);
    check("hold_cycles", cyc, 6);

    // Reset mid-operation clears immediately, then a fresh job works
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'hABCD;
    dir     = 1'b0;
    arith   = 1'b0;
    step    = 2'd1;
    n_steps = CNT_W'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_shift_out", shift_out, 0);
    check("midrst_carry", carry_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b0;
    run_job(16'h0001, 1'b0, 1'b0, 2'd1, 4, 64'd0, 1'b0, fd, fc, cyc);
    check("post_rst_data", fd, 16'h0010);
    check("post_rst_cycles", cyc, 4);

    // Randomized jobs against the reference model
    for (int j = 0; j < 40; j++) begin
      int unsigned ev;
      bit ec;
      r_d     = DW'($urandom);
      r_dir_v = 1'($urandom_range(0, 1));
      r_ar    = 1'($urandom_range(0, 1));
      r_st    = STEP_W'($urandom_range(0, 3));
      r_n     = $urandom_range(0, 20);
      run_job(r_d, r_dir_v, r_ar, r_st, r_n, {$urandom, $urandom} & {$urandom, $urandom},
              1'b1, fd, fc, cyc);
      ref_model(r_d, r_dir_v, r_ar, r_st, r_n, ev, ec);
      check("rand_final_data", fd, ev & 32'hFFFF);
      check("rand_final_carry", fc, ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
